// File: rtl/sha256_compress.sv
// sha256_compress: iterative single-block SHA-256 compression.
// One round per clock (64 rounds), then a single feed-forward cycle that
// adds the working variables back onto the captured chaining state.
module sha256_compress (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] chunk,
    input  logic [255:0] state_in,
    output logic [255:0] state_out,
    output logic         finish
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [5:0]   round_q, round_d;
    logic [31:0]  w_q [16];      // w_q[0] is W_t, w_q[15] is W_t+15
    logic [31:0]  w_d [16];
    logic [31:0]  wk_q [8];      // working variables a..h
    logic [31:0]  wk_d [8];
    logic [31:0]  hin_q [8];     // captured chaining state H0..H7
    logic [31:0]  hin_d [8];
    logic [255:0] state_out_q, state_out_d;
    logic         finish_q, finish_d;

    logic [31:0]  t1, t2, w_new;

    // State register and datapath flops, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= IDLE;
            round_q     <= 6'd0;
            state_out_q <= '0;
            finish_q    <= 1'b0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                wk_q[i]  <= '0;
                hin_q[i] <= '0;
            end
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            state_out_q <= state_out_d;
            finish_q    <= finish_d;
            for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
            for (int i = 0; i < 8; i++) begin
                wk_q[i]  <= wk_d[i];
                hin_q[i] <= hin_d[i];
            end
        end
    end

    // Next-state logic: capture -> 64 rounds -> one feed-forward cycle
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start) fsm_d = ROUND;
            ROUND:   if (round_q == 6'd63) fsm_d = DONE;
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Round function and message-schedule expansion for the current t
    always_comb begin
        t1 = wk_q[7]
           + (rotr(wk_q[4], 6) ^ rotr(wk_q[4], 11) ^ rotr(wk_q[4], 25))
           + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]))
           + K[round_q] + w_q[0];
        t2 = (rotr(wk_q[0], 2) ^ rotr(wk_q[0], 13) ^ rotr(wk_q[0], 22))
           + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
        // W_t+16 from the window; values generated past round 47 are never consumed
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
              + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
              + w_q[0];
    end

    // Output/datapath logic per state
    always_comb begin
        round_d     = round_q;
        state_out_d = state_out_q;
        finish_d    = 1'b0;
        for (int i = 0; i < 16; i++) w_d[i] = w_q[i];
        for (int i = 0; i < 8; i++) begin
            wk_d[i]  = wk_q[i];
            hin_d[i] = hin_q[i];
        end
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    round_d = 6'd0;
                    for (int i = 0; i < 16; i++) w_d[i] = chunk[511 - 32*i -: 32];
                    for (int i = 0; i < 8; i++) begin
                        hin_d[i] = state_in[255 - 32*i -: 32];
                        wk_d[i]  = state_in[255 - 32*i -: 32];
                    end
                end
            end
            ROUND: begin
                round_d = round_q + 6'd1;
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
                w_d[15] = w_new;
                for (int i = 1; i < 8; i++) wk_d[i] = wk_q[i - 1];
                wk_d[4] = wk_q[3] + t1;
                wk_d[0] = t1 + t2;
            end
            DONE: begin
                for (int i = 0; i < 8; i++)
                    state_out_d[255 - 32*i -: 32] = hin_q[i] + wk_q[i];
                finish_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_out = state_out_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Testbench for sha256_compress: directed vectors, scoreboard queue checked
// by an independent monitor on every finish pulse.
module tb_sha256_compress;

    logic         clk;
    logic         reset;
    logic         start;
    logic [511:0] chunk;
    logic [255:0] state_in;
    logic [255:0] state_out;
    logic         finish;

    sha256_compress dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .chunk     (chunk),
        .state_in  (state_in),
        .state_out (state_out),
        .finish    (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] BLK_EMPTY = {1'b1, 511'b0};
    localparam logic [511:0] BLK_ABC   = {24'h616263, 1'b1, 423'b0, 64'd24};

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression: full 64-word schedule computed up front
    function automatic logic [255:0] sha_model(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] x1, x2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [255:0] exp_q [$];
    int           cap_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every finish pulse
    logic prev_fin = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_fin = 1'b0;
        end else begin
            if (prev_fin) check_int("finish_one_cycle", int'(finish), 0);
            if (finish) begin
                if (exp_q.size() == 0) begin
                    check_int("unexpected_finish", 1, 0);
                end else begin
                    logic [255:0] e;
                    int c;
                    e = exp_q.pop_front();
                    c = cap_q.pop_front();
                    check256("digest", state_out, e);
                    check_int("latency", cyc - c, 65);
                    $display("txn: cycle=%0d digest=%h", cyc, state_out);
                end
            end
            prev_fin = finish;
        end
    end

    // Caller must be positioned just after a negedge; drives start for one capture edge
    task automatic issue(input logic [511:0] c, input logic [255:0] s, input logic [255:0] e);
        start    = 1'b1;
        chunk    = c;
        state_in = s;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        cap_q.push_back(cyc);
        start = 1'b0;
        for (int i = 0; i < 16; i++) chunk[32*i +: 32] = $urandom;
        for (int i = 0; i < 8; i++) state_in[32*i +: 32] = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_int("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            cap_q.delete();
        end
    endtask

    task automatic hold_check(input logic [255:0] e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check256("hold", state_out, e);
        end
    endtask

    logic [255:0] dig_chain;

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        chunk    = '0;
        state_in = '0;

        // Model sanity against published digests
        check256("model_empty", sha_model(IV, BLK_EMPTY), DIG_EMPTY);
        check256("model_abc", sha_model(IV, BLK_ABC), DIG_ABC);

        repeat (3) @(negedge clk);
        check_int("reset_finish", int'(finish), 0);
        check256("reset_state_out", state_out, '0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Empty string, then hold and chunk-change immunity (issue scrambles inputs)
        issue(BLK_EMPTY, IV, DIG_EMPTY);
        wait_drain();
        hold_check(DIG_EMPTY);

        // abc
        @(negedge clk);
        issue(BLK_ABC, IV, DIG_ABC);
        wait_drain();
        hold_check(DIG_ABC);

        // Busy ignore: second start at round 20 must be dropped
        @(negedge clk);
        issue(BLK_EMPTY, IV, DIG_EMPTY);
        repeat (20) @(posedge clk);
        #1;
        start    = 1'b1;
        chunk    = BLK_ABC;
        state_in = IV;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (80) @(negedge clk);

        // Reset mid-run at round 30
        @(negedge clk);
        issue(BLK_ABC, IV, DIG_ABC);
        repeat (30) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_int("abort_finish", int'(finish), 0);
        check256("abort_state_out", state_out, '0);
        void'(exp_q.pop_back());
        void'(cap_q.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (70) @(negedge clk);
        check_int("abort_no_finish", int'(finish), 0);
        issue(BLK_ABC, IV, DIG_ABC);
        wait_drain();

        // Back-to-back chaining: start in the cycle right after finish
        @(negedge clk);
        issue(BLK_EMPTY, IV, DIG_EMPTY);
        begin
            int n;
            n = 0;
            while (!finish && n < 100) begin
                @(negedge clk);
                n++;
            end
            check_int("chain_first_finish", int'(finish), 1);
        end
        dig_chain = sha_model(DIG_EMPTY, BLK_EMPTY);
        issue(BLK_EMPTY, DIG_EMPTY, dig_chain);
        wait_drain();
        hold_check(dig_chain);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
